ct_ifu_icache_predecd_ctrl: RTL and testbench

//  Access controller for one icache predecode array bank.

---
 rtl/ct_ifu_icache_predecd_ctrl_pkg.sv | 30 +++
 rtl/ct_ifu_icache_predecd_ctrl_if.sv | 44 ++++
 rtl/ct_ifu_predecd_inv_fsm.sv | 66 ++++++
 rtl/ct_ifu_icache_predecd_ctrl.sv | 83 ++++++++
 tb/tb_ct_ifu_icache_predecd_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ct_ifu_icache_predecd_ctrl_pkg.sv
// Shared IFU definitions for the icache predecode array controller.
package ct_ifu_icache_predecd_ctrl_pkg;

  // Invalidate sweep FSM states.
  typedef enum logic [1:0] {
    PdIdle  = 2'd0,
    PdSweep = 2'd1,
    PdDone  = 2'd2
  } pd_state_e;

  // MSB of the ifu index used by the predecode SRAM, derived from the icache size.
`ifdef ICACHE_64K
  localparam int unsigned IcacheIdxHi = 13;
`elsif ICACHE_16K
  localparam int unsigned IcacheIdxHi = 11;
`else
  localparam int unsigned IcacheIdxHi = 12;
`endif

  localparam int unsigned PdIndexW = 16;

  // Value written into every entry by the invalidate sweep.
  localparam logic [31:0] PredecdInvVal = 32'b0;

  // SRAM index of a fetch/refill address: the low three bits never reach the array.
  function automatic logic [PdIndexW-1:0] pd_line_index(input logic [PdIndexW-1:0] idx);
    return {idx[PdIndexW-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/ct_ifu_icache_predecd_ctrl_if.sv
// Request/grant and SRAM-control bundle of the predecode array controller.
interface ct_ifu_icache_predecd_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  // Requesters
  logic              cp0_ifu_icache_inv_req;
  logic              refill_predecd_vld;
  logic [15:0]       refill_predecd_index;
  logic [DATA_W-1:0] refill_predecd_din;
  logic              ifctrl_predecd_rd_req;
  logic [15:0]       ifctrl_predecd_index;
  // Grants and status
  logic              predecd_refill_grnt;
  logic              predecd_ifctrl_grnt;
  logic              predecd_ifctrl_rd_vld;
  logic              predecd_inv_busy;
  logic              predecd_inv_done;
  // SRAM control
  logic              ifu_icache_predecd_cen_b;
  logic              ifu_icache_predecd_wen_b;
  logic [15:0]       ifu_icache_predecd_index;
  logic [DATA_W-1:0] ifu_icache_predecd_din;
  logic              ifu_icache_predecd_clk_en;

  // Requester side: IFU pipeline, refill unit and CP0.
  modport master (
    output cp0_ifu_icache_inv_req, refill_predecd_vld, refill_predecd_index,
           refill_predecd_din, ifctrl_predecd_rd_req, ifctrl_predecd_index,
    input  predecd_refill_grnt, predecd_ifctrl_grnt, predecd_ifctrl_rd_vld,
           predecd_inv_busy, predecd_inv_done, ifu_icache_predecd_cen_b,
           ifu_icache_predecd_wen_b, ifu_icache_predecd_index, ifu_icache_predecd_din,
           ifu_icache_predecd_clk_en
  );

  // Controller side.
  modport slave (
    input  cp0_ifu_icache_inv_req, refill_predecd_vld, refill_predecd_index,
           refill_predecd_din, ifctrl_predecd_rd_req, ifctrl_predecd_index,
    output predecd_refill_grnt, predecd_ifctrl_grnt, predecd_ifctrl_rd_vld,
           predecd_inv_busy, predecd_inv_done, ifu_icache_predecd_cen_b,
           ifu_icache_predecd_wen_b, ifu_icache_predecd_index, ifu_icache_predecd_din,
           ifu_icache_predecd_clk_en
  );
endinterface

// File: rtl/ct_ifu_predecd_inv_fsm.sv
// Invalidate sweep: walks every predecode entry once, one write per cycle.
module ct_ifu_predecd_inv_fsm
  import ct_ifu_icache_predecd_ctrl_pkg::*;
#(
  parameter int unsigned IDX_HI = IcacheIdxHi
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inv_req_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [PdIndexW-1:0] sweep_index_o
);

  localparam int unsigned CntW  = IDX_HI - 2;
  localparam int unsigned DEPTH = 1 << CntW;
  localparam logic [CntW-1:0] CntLast = CntW'(DEPTH - 1);

  pd_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // State and sweep counter; reset aborts a sweep with no done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PdIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; inv_req outside idle is dropped, not queued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      PdIdle: begin
        if (inv_req_i) begin
          state_d = PdSweep;
          cnt_d   = '0;
        end
      end
      PdSweep: begin
        busy_o = 1'b1;
        // Terminal detected by compare so the last write is never skipped by a wrap.
        if (cnt_q == CntLast) begin
          state_d = PdDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PdDone: begin
        done_o  = 1'b1;
        state_d = PdIdle;
      end
      default: state_d = PdIdle;
    endcase
  end

  assign sweep_index_o = PdIndexW'({cnt_q, 3'b000});

endmodule

// File: rtl/ct_ifu_icache_predecd_ctrl.sv
// Predecode array bank controller: arbitrates sweep, refill and fetch onto one SRAM port.
module ct_ifu_icache_predecd_ctrl
  import ct_ifu_icache_predecd_ctrl_pkg::*;
#(
  parameter int unsigned IDX_HI = IcacheIdxHi,
  parameter int unsigned DATA_W = 32
) (
  input  logic                          forever_cpuclk,
  input  logic                          cpurst_b,
  ct_ifu_icache_predecd_ctrl_if.slave   bus
);

  logic                sweep_busy;
  logic                sweep_done;
  logic [PdIndexW-1:0] sweep_index;

  logic                refill_grnt;
  logic                ifctrl_grnt;
  logic                cen_b;
  logic                wen_b;
  logic [PdIndexW-1:0] sram_index;
  logic [DATA_W-1:0]   sram_din;
  logic                rd_vld_q;

  ct_ifu_predecd_inv_fsm #(
    .IDX_HI (IDX_HI)
  ) u_inv_fsm (
    .clk_i         (forever_cpuclk),
    .rst_ni        (cpurst_b),
    .inv_req_i     (bus.cp0_ifu_icache_inv_req),
    .busy_o        (sweep_busy),
    .done_o        (sweep_done),
    .sweep_index_o (sweep_index)
  );

  // Fixed priority: sweep write > refill write > fetch read; one access per cycle.
  always_comb begin
    refill_grnt = 1'b0;
    ifctrl_grnt = 1'b0;
    cen_b       = 1'b1;
    wen_b       = 1'b1;
    sram_index  = '0;
    sram_din    = '0;
    if (sweep_busy) begin
      cen_b      = 1'b0;
      wen_b      = 1'b0;
      sram_index = sweep_index;
      sram_din   = DATA_W'(PredecdInvVal);
    end else if (bus.refill_predecd_vld) begin
      refill_grnt = 1'b1;
      cen_b       = 1'b0;
      wen_b       = 1'b0;
      sram_index  = pd_line_index(bus.refill_predecd_index);
      sram_din    = bus.refill_predecd_din;
    end else if (bus.ifctrl_predecd_rd_req) begin
      ifctrl_grnt = 1'b1;
      cen_b       = 1'b0;
      sram_index  = pd_line_index(bus.ifctrl_predecd_index);
    end
  end

  // SRAM dout is valid the cycle after a granted read.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= ifctrl_grnt;
    end
  end

  assign bus.predecd_refill_grnt       = refill_grnt;
  assign bus.predecd_ifctrl_grnt       = ifctrl_grnt;
  assign bus.predecd_ifctrl_rd_vld     = rd_vld_q;
  assign bus.predecd_inv_busy          = sweep_busy;
  assign bus.predecd_inv_done          = sweep_done;
  assign bus.ifu_icache_predecd_cen_b  = cen_b;
  assign bus.ifu_icache_predecd_wen_b  = wen_b;
  assign bus.ifu_icache_predecd_index  = sram_index;
  assign bus.ifu_icache_predecd_din    = sram_din;
  // Gated clock only ticks on access cycles.
  assign bus.ifu_icache_predecd_clk_en = ~cen_b;

endmodule

// File: tb/tb_ct_ifu_icache_predecd_ctrl.sv
// Bench for the predecode array controller against a cycle-level behavioural model.
module tb_ct_ifu_icache_predecd_ctrl;

  localparam int Depth = 1 << (12 - 2);

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  ct_ifu_icache_predecd_ctrl_if #(.DATA_W(32)) bus ();

  ct_ifu_icache_predecd_ctrl #(
    .IDX_HI (12),
    .DATA_W (32)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .bus            (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: sweep position (-1 when not sweeping), pending done pulse, pending read data.
  int m_cnt   = -1;
  bit m_done  = 1'b0;
  bit m_rdvld = 1'b0;

  int busy_cycles  = 0;
  int done_pulses  = 0;
  int sweep_writes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs for the current inputs, then advance the model.
  task automatic step(input string tag);
    logic [15:0] e_idx;
    logic [31:0] e_din;
    bit e_rg, e_fg, e_cen, e_wen;
    #1;
    e_rg = 0; e_fg = 0; e_cen = 1; e_wen = 1; e_idx = '0; e_din = '0;
    if (m_cnt >= 0) begin
      e_cen = 0; e_wen = 0; e_idx = 16'(m_cnt * 8);
    end else if (bus.refill_predecd_vld) begin
      e_rg = 1; e_cen = 0; e_wen = 0;
      e_idx = bus.refill_predecd_index & 16'hFFF8;
      e_din = bus.refill_predecd_din;
    end else if (bus.ifctrl_predecd_rd_req) begin
      e_fg = 1; e_cen = 0;
      e_idx = bus.ifctrl_predecd_index & 16'hFFF8;
    end
    chk({tag, ":refill_grnt"}, 32'(bus.predecd_refill_grnt), 32'(e_rg));
    chk({tag, ":ifctrl_grnt"}, 32'(bus.predecd_ifctrl_grnt), 32'(e_fg));
    chk({tag, ":cen_b"}, 32'(bus.ifu_icache_predecd_cen_b), 32'(e_cen));
    chk({tag, ":wen_b"}, 32'(bus.ifu_icache_predecd_wen_b), 32'(e_wen));
    chk({tag, ":clk_en"}, 32'(bus.ifu_icache_predecd_clk_en), 32'(!e_cen));
    chk({tag, ":index"}, 32'(bus.ifu_icache_predecd_index), 32'(e_idx));
    chk({tag, ":din"}, bus.ifu_icache_predecd_din, e_din);
    chk({tag, ":busy"}, 32'(bus.predecd_inv_busy), 32'(m_cnt >= 0));
    chk({tag, ":done"}, 32'(bus.predecd_inv_done), 32'(m_done));
    chk({tag, ":rd_vld"}, 32'(bus.predecd_ifctrl_rd_vld), 32'(m_rdvld));
    if (bus.predecd_inv_busy) busy_cycles++;
    if (bus.predecd_inv_done) done_pulses++;
    if (bus.predecd_inv_busy && !bus.ifu_icache_predecd_cen_b && !bus.ifu_icache_predecd_wen_b)
      sweep_writes++;
    @(posedge clk);
    m_rdvld = e_fg;
    if (m_cnt >= 0) begin
      if (m_cnt == Depth - 1) begin
        m_cnt  = -1;
        m_done = 1;
      end else begin
        m_cnt++;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (bus.cp0_ifu_icache_inv_req) begin
      m_cnt = 0;
    end
    #1;
  endtask

  // Run a sweep to completion; optionally re-pulse inv_req at sweep cycle inject_at and in done.
  task automatic run_sweep(input string tag, input int inject_at);
    int n = 0;
    while ((m_cnt >= 0 || m_done) && n < Depth + 50) begin
      bus.cp0_ifu_icache_inv_req = (n == inject_at) || (m_done && inject_at >= 0);
      step(tag);
      n++;
    end
    bus.cp0_ifu_icache_inv_req = 1'b0;
    chk({tag, ":bounded"}, 32'(n < Depth + 50), 32'd1);
  endtask

  task automatic clear_inputs();
    bus.cp0_ifu_icache_inv_req = 1'b0;
    bus.refill_predecd_vld     = 1'b0;
    bus.refill_predecd_index   = '0;
    bus.refill_predecd_din     = '0;
    bus.ifctrl_predecd_rd_req  = 1'b0;
    bus.ifctrl_predecd_index   = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_b = 1'b0;
    #3;
    // Reset values
    chk("rst:cen_b", 32'(bus.ifu_icache_predecd_cen_b), 32'd1);
    chk("rst:wen_b", 32'(bus.ifu_icache_predecd_wen_b), 32'd1);
    chk("rst:clk_en", 32'(bus.ifu_icache_predecd_clk_en), 32'd0);
    chk("rst:rd_vld", 32'(bus.predecd_ifctrl_rd_vld), 32'd0);
    chk("rst:busy", 32'(bus.predecd_inv_busy), 32'd0);
    chk("rst:index", 32'(bus.ifu_icache_predecd_index), 32'd0);
    @(posedge clk);
    #1 rst_b = 1'b1;

    // 1. Idle
    for (int i = 0; i < 10; i++) step("idle");

    // 2. Single fetch read, then rd_vld for one cycle only
    bus.ifctrl_predecd_rd_req = 1'b1;
    bus.ifctrl_predecd_index  = 16'h0128;
    step("fetch");
    clear_inputs();
    step("fetch_vld");
    step("fetch_after");

    // Back-to-back reads
    for (int i = 0; i < 4; i++) begin
      bus.ifctrl_predecd_rd_req = 1'b1;
      bus.ifctrl_predecd_index  = 16'(i * 16 + 5);
      step("fetch_b2b");
    end
    clear_inputs();
    step("fetch_b2b_end");

    // 3. Refill and fetch collide; fetch holds and wins next cycle
    bus.refill_predecd_vld    = 1'b1;
    bus.refill_predecd_index  = 16'h0040;
    bus.refill_predecd_din    = 32'hA5A5_1234;
    bus.ifctrl_predecd_rd_req = 1'b1;
    bus.ifctrl_predecd_index  = 16'h0128;
    step("collide");
    bus.refill_predecd_vld = 1'b0;
    step("collide_fetch");
    clear_inputs();
    step("collide_end");

    // 4. Full sweep with inv_req colliding with a refill; requesters held throughout
    busy_cycles = 0; done_pulses = 0; sweep_writes = 0;
    bus.refill_predecd_vld     = 1'b1;
    bus.refill_predecd_index   = 16'h1237;
    bus.refill_predecd_din     = 32'hDEAD_BEEF;
    bus.ifctrl_predecd_rd_req  = 1'b1;
    bus.ifctrl_predecd_index   = 16'h0777;
    bus.cp0_ifu_icache_inv_req = 1'b1;
    step("inv_start");
    bus.cp0_ifu_icache_inv_req = 1'b0;
    run_sweep("sweep", -1);
    clear_inputs();
    step("sweep_after");
    chk("sweep:busy_cycles", 32'(busy_cycles), 32'(Depth));
    chk("sweep:done_pulses", 32'(done_pulses), 32'd1);
    chk("sweep:writes", 32'(sweep_writes), 32'(Depth));

    // 5. Re-issued inv_req mid-sweep and during done is ignored
    busy_cycles = 0; done_pulses = 0; sweep_writes = 0;
    bus.cp0_ifu_icache_inv_req = 1'b1;
    step("inv2_start");
    run_sweep("sweep2", 500);
    for (int i = 0; i < 3; i++) step("sweep2_after");
    chk("sweep2:busy_cycles", 32'(busy_cycles), 32'(Depth));
    chk("sweep2:done_pulses", 32'(done_pulses), 32'd1);
    chk("sweep2:writes", 32'(sweep_writes), 32'(Depth));

    // 6. Reset at sweep count 300 aborts without a done pulse
    done_pulses = 0;
    bus.cp0_ifu_icache_inv_req = 1'b1;
    step("inv3_start");
    bus.cp0_ifu_icache_inv_req = 1'b0;
    for (int i = 0; i < Depth && m_cnt != 300; i++) step("sweep3");
    rst_b = 1'b0;
    #1;
    chk("abort:busy", 32'(bus.predecd_inv_busy), 32'd0);
    chk("abort:cen_b", 32'(bus.ifu_icache_predecd_cen_b), 32'd1);
    chk("abort:done", 32'(bus.predecd_inv_done), 32'd0);
    m_cnt = -1; m_done = 0; m_rdvld = 0;
    @(posedge clk);
    #1 rst_b = 1'b1;
    for (int i = 0; i < 3; i++) step("abort_idle");
    chk("abort:no_done", 32'(done_pulses), 32'd0);
    bus.cp0_ifu_icache_inv_req = 1'b1;
    step("inv4_start");
    bus.cp0_ifu_icache_inv_req = 1'b0;
    #1 chk("restart:index", 32'(bus.ifu_icache_predecd_index), 32'd0);
    run_sweep("sweep4", -1);

    // Randomized traffic with occasional invalidates
    for (int i = 0; i < 600; i++) begin
      bus.refill_predecd_vld     = ($urandom_range(0, 3) == 0);
      bus.refill_predecd_index   = 16'($urandom);
      bus.refill_predecd_din     = $urandom;
      bus.ifctrl_predecd_rd_req  = ($urandom_range(0, 1) == 1);
      bus.ifctrl_predecd_index   = 16'($urandom);
      bus.cp0_ifu_icache_inv_req = ($urandom_range(0, 399) == 0);
      step("rand");
    end
    clear_inputs();
    run_sweep("rand_drain", -1);
    step("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
